traffic_light_monitor: RTL

Receive-side checker for the traffic-light controller's `light_ctrl`/`light_t` outputs, which are generated on `sys_clk_1s`. It brings both buses into the `sys_clk` domain and filters them for stability. It then tracks the phase sequence, checks that the countdown and phase order are legal, and reports sticky faults plus a completed-cycle count for status logic and the display path.

---
 rtl/traffic_light_pkg.sv | 63 ++++++
 rtl/sync_stable_filter.sv | 53 +++++
 rtl/traffic_light_monitor.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/traffic_light_pkg.sv
// Lamp codes, countdown defaults, phase/state enums and fault codes shared by controller and monitor.
// Pure declarations: no latency and no backpressure.
package traffic_light_pkg;

    localparam logic [2:0] CTRL_OFF    = 3'b000;
    localparam logic [2:0] CTRL_GREEN  = 3'b001;
    localparam logic [2:0] CTRL_YELLOW = 3'b010;
    localparam logic [2:0] CTRL_RED    = 3'b100;

    localparam logic [7:0] GREEN_TIME_DEF  = 8'd20;
    localparam logic [7:0] YELLOW_TIME_DEF = 8'd17;
    localparam logic [7:0] RED_TIME_DEF    = 8'd14;

    typedef enum logic [1:0] {
        PH_OFF    = 2'd0,
        PH_GREEN  = 2'd1,
        PH_YELLOW = 2'd2,
        PH_RED    = 2'd3
    } phase_t;

    typedef enum logic [2:0] {
        ST_RESYNC, ST_OFF, ST_GREEN, ST_YELLOW, ST_RED, ST_FAULT
    } mon_state_t;

    localparam logic [2:0] FC_NONE         = 3'd0;
    localparam logic [2:0] FC_ILLEGAL_CTRL = 3'd1;
    localparam logic [2:0] FC_BAD_SEQ      = 3'd2;
    localparam logic [2:0] FC_BAD_COUNT    = 3'd3;
    localparam logic [2:0] FC_STALL        = 3'd4;

    function automatic logic ctrl_legal(input logic [2:0] c);
        return (c == CTRL_OFF) || (c == CTRL_GREEN) || (c == CTRL_YELLOW) || (c == CTRL_RED);
    endfunction

    function automatic phase_t ctrl_to_phase(input logic [2:0] c);
        case (c)
            CTRL_GREEN:  return PH_GREEN;
            CTRL_YELLOW: return PH_YELLOW;
            CTRL_RED:    return PH_RED;
            default:     return PH_OFF;
        endcase
    endfunction

    function automatic mon_state_t phase_to_state(input phase_t p);
        case (p)
            PH_GREEN:  return ST_GREEN;
            PH_YELLOW: return ST_YELLOW;
            PH_RED:    return ST_RED;
            default:   return ST_OFF;
        endcase
    endfunction

    // The only legal lamp changes: OFF->GREEN, GREEN->YELLOW, YELLOW->RED, RED->GREEN.
    function automatic logic seq_legal(input phase_t from_ph, input phase_t to_ph);
        case (from_ph)
            PH_OFF:    return to_ph == PH_GREEN;
            PH_GREEN:  return to_ph == PH_YELLOW;
            PH_YELLOW: return to_ph == PH_RED;
            default:   return to_ph == PH_GREEN;
        endcase
    endfunction

endpackage

// File: rtl/sync_stable_filter.sv
// 2-flop synchronizer plus stability filter; o_evt fires (combinationally) 1+STABLE_CYCLES edges after a change.
// No backpressure: o_word/o_evt are a free-running strobe, o_acc updates on the event edge.
module sync_stable_filter #(
    parameter int WIDTH         = 11,
    parameter int STABLE_CYCLES = 2
) (
    input  logic             sys_clk,
    input  logic             sys_rst_p,
    input  logic [WIDTH-1:0] i_dat,
    output logic [WIDTH-1:0] o_word,
    output logic [WIDTH-1:0] o_acc,
    output logic             o_evt
);

    localparam int CW = $clog2(STABLE_CYCLES + 1) + 1;

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;
    logic [WIDTH-1:0] r_last;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_run;
    logic [CW-1:0]    w_run;
    logic             w_evt;

    // w_run counts synchronized samples equal to r_sync, including the current one.
    always_comb begin
        w_run = (r_sync == r_last) ? r_run + 1'b1 : CW'(1);
        w_evt = (w_run >= CW'(STABLE_CYCLES)) && (r_sync != r_acc);
    end

    always_ff @(posedge sys_clk or posedge sys_rst_p) begin
        if (sys_rst_p) begin
            r_meta <= '0;
            r_sync <= '0;
            r_last <= '0;
            r_acc  <= '0;
            r_run  <= '0;
        end else begin
            r_meta <= i_dat;
            r_sync <= r_meta;
            r_last <= r_sync;
            r_run  <= (w_run >= CW'(STABLE_CYCLES)) ? CW'(STABLE_CYCLES) : w_run;
            if (w_evt) begin
                r_acc <= r_sync;
            end
        end
    end

    assign o_word = r_sync;
    assign o_acc  = r_acc;
    assign o_evt  = w_evt;

endmodule

// File: rtl/traffic_light_monitor.sv
// Checks the controller's lamp/countdown buses for legal order and counts; sticky fault and cycle count.
// Outputs update on the acceptance edge, 2+STABLE_CYCLES edges after a stable change; no backpressure.
module traffic_light_monitor
    import traffic_light_pkg::*;
#(
    parameter logic [7:0]  GREEN_TIME     = GREEN_TIME_DEF,
    parameter logic [7:0]  YELLOW_TIME    = YELLOW_TIME_DEF,
    parameter logic [7:0]  RED_TIME       = RED_TIME_DEF,
    parameter int          STABLE_CYCLES  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 150_000_000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_p,
    input  logic [7:0]  light_t,
    input  logic [2:0]  light_ctrl,
    input  logic        clr_fault,
    output logic [1:0]  phase,
    output logic        phase_valid,
    output logic        tick,
    output logic        fault,
    output logic [2:0]  fault_code,
    output logic [15:0] cycle_cnt
);

    localparam logic [27:0] STALL_LAST = 28'(TIMEOUT_CYCLES - 1);

    logic [10:0] w_word;
    logic [10:0] w_acc;
    logic        w_evt;
    logic [2:0]  w_new_ctrl, w_old_ctrl;
    logic [7:0]  w_new_t, w_old_t;
    phase_t      w_new_ph;
    logic        w_cnt_ok;
    logic [2:0]  w_chk;

    mon_state_t  r_state, w_state_nxt;
    phase_t      r_phase, w_phase_nxt;
    logic        r_phase_valid, w_pv_nxt;
    logic        r_tick;
    logic        r_fault, w_fault_nxt;
    logic [2:0]  r_code, w_code_nxt;
    logic [27:0] r_stall_cnt, w_stall_nxt;
    logic [15:0] r_cycle_cnt;
    logic        w_cyc_inc;

    sync_stable_filter #(
        .WIDTH         (11),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .sys_clk   (sys_clk),
        .sys_rst_p (sys_rst_p),
        .i_dat     ({light_ctrl, light_t}),
        .o_word    (w_word),
        .o_acc     (w_acc),
        .o_evt     (w_evt)
    );

    assign w_new_ctrl = w_word[10:8];
    assign w_new_t    = w_word[7:0];
    assign w_old_ctrl = w_acc[10:8];
    assign w_old_t    = w_acc[7:0];

    // Both checks compare the candidate word against the previously accepted one.
    always_comb begin
        w_new_ph = ctrl_to_phase(w_new_ctrl);
        w_cnt_ok = 1'b0;
        if (w_new_t != 8'd0) begin
            if (w_old_t >= 8'd2) begin
                w_cnt_ok = (w_new_t == w_old_t - 8'd1);
            end else if (w_old_t == 8'd1) begin
                w_cnt_ok = (w_new_t == GREEN_TIME) || (w_new_t == YELLOW_TIME) || (w_new_t == RED_TIME);
            end
        end
        w_chk = FC_NONE;
        if (!ctrl_legal(w_new_ctrl)) begin
            w_chk = FC_ILLEGAL_CTRL;
        end else if ((w_new_ctrl != w_old_ctrl) && !seq_legal(r_phase, w_new_ph)) begin
            w_chk = FC_BAD_SEQ;
        end else if ((w_new_t != w_old_t) && !w_cnt_ok) begin
            w_chk = FC_BAD_COUNT;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_fault_nxt = r_fault;
        w_code_nxt  = r_code;
        w_stall_nxt = r_stall_cnt;
        w_cyc_inc   = 1'b0;
        case (r_state)
            ST_RESYNC: begin
                w_stall_nxt = '0;
                if (w_evt) begin
                    if (ctrl_legal(w_new_ctrl)) begin
                        w_state_nxt = phase_to_state(w_new_ph);
                        w_phase_nxt = w_new_ph;
                    end else begin
                        w_state_nxt = ST_FAULT;
                        w_fault_nxt = 1'b1;
                        w_code_nxt  = FC_ILLEGAL_CTRL;
                    end
                end
            end
            ST_FAULT: begin
                w_stall_nxt = '0;
                if (clr_fault) begin
                    w_state_nxt = ST_RESYNC;
                    w_fault_nxt = 1'b0;
                    w_code_nxt  = FC_NONE;
                end
            end
            default: begin
                if (w_evt) begin
                    w_stall_nxt = '0;
                    if (w_chk != FC_NONE) begin
                        w_state_nxt = ST_FAULT;
                        w_fault_nxt = 1'b1;
                        w_code_nxt  = w_chk;
                    end else begin
                        w_state_nxt = phase_to_state(w_new_ph);
                        w_phase_nxt = w_new_ph;
                        w_cyc_inc   = (r_phase == PH_RED) && (w_new_ph == PH_GREEN);
                    end
                end else if (r_stall_cnt == STALL_LAST) begin
                    w_stall_nxt = '0;
                    w_state_nxt = ST_FAULT;
                    w_fault_nxt = 1'b1;
                    w_code_nxt  = FC_STALL;
                end else begin
                    w_stall_nxt = r_stall_cnt + 28'd1;
                end
            end
        endcase
        w_pv_nxt = (w_state_nxt != ST_RESYNC) && (w_state_nxt != ST_FAULT);
    end

    always_ff @(posedge sys_clk or posedge sys_rst_p) begin
        if (sys_rst_p) begin
            r_state       <= ST_RESYNC;
            r_phase       <= PH_OFF;
            r_phase_valid <= 1'b0;
            r_tick        <= 1'b0;
            r_fault       <= 1'b0;
            r_code        <= FC_NONE;
            r_stall_cnt   <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_phase       <= w_phase_nxt;
            r_phase_valid <= w_pv_nxt;
            r_tick        <= w_evt;
            r_fault       <= w_fault_nxt;
            r_code        <= w_code_nxt;
            r_stall_cnt   <= w_stall_nxt;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst_p) begin
        if (sys_rst_p) begin
            r_cycle_cnt <= '0;
        end else if (w_cyc_inc && (r_cycle_cnt != 16'hFFFF)) begin
            r_cycle_cnt <= r_cycle_cnt + 16'd1;
        end
    end

    assign phase       = r_phase;
    assign phase_valid = r_phase_valid;
    assign tick        = r_tick;
    assign fault       = r_fault;
    assign fault_code  = r_code;
    assign cycle_cnt   = r_cycle_cnt;

endmodule
